// File: rtl/async_fifo_pkg.sv
// Shared state encoding and width helper for the async FIFO write-side arbiter.
// Latency: none, types and constant functions only.
// Backpressure: none.
package async_fifo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Ceiling log2; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first active requester after the last grantee, with wrap-around.
// Latency: purely combinational.
// Backpressure: none; vld is low when no requester is active.
module rr_pick
   import async_fifo_pkg::*;
#(
   parameter int num_req = 4,
   parameter int idw     = clog2(num_req)
) (
   input  logic [num_req-1:0] req,
   input  logic [idw-1:0]     last,
   output logic [idw-1:0]     next,
   output logic               vld
);

   localparam logic [idw:0] num_c = (idw+1)'(num_req);

   logic [idw:0] sum;

   // Walk offsets from farthest to nearest so the nearest active requester wins;
   // the last grantee itself (offset num_req) has the lowest priority.
   always_comb begin
      next = last;
      vld  = 1'b0;
      sum  = '0;
      for (int off = num_req; off >= 1; off--) begin
         sum = {1'b0, last} + (idw+1)'(off);
         if (sum >= num_c) sum = sum - num_c;
         if (req[sum[idw-1:0]]) begin
            next = sum[idw-1:0];
            vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port; WR_ARB_STATS_EN adds a stall counter.
// Latency: one IDLE arbitration cycle per grant, then one word per cycle for up to burst words.
// Backpressure: full gates winc/ack through a single AND; the grant is held while stalled.
module async_fifo_wr_arbiter
   import async_fifo_pkg::*;
#(
   parameter int width   = 8,
   parameter int num_req = 4,
   parameter int burst   = 4
) (
   input  logic                      w_clk,
   input  logic                      w_rst,
   input  logic [num_req-1:0]        req,
   input  logic [num_req*width-1:0]  req_data,
   output logic [num_req-1:0]        ack,
   input  logic                      full,
   output logic                      winc,
   output logic [width-1:0]          w_data,
   output logic [clog2(num_req)-1:0] gnt_id,
   output logic                      busy
`ifdef WR_ARB_STATS_EN
   ,
   input  logic                      stats_clr,
   output logic [15:0]               stall_cnt
`endif
);

   localparam int idw = clog2(num_req);
   localparam int cw  = clog2(burst) + 1;
   localparam logic [cw-1:0] burst_c = cw'(burst);

   arb_state_t          state;
   logic [cw-1:0]       cnt;
   logic [width-1:0]    slice [num_req];
   logic [idw-1:0]      pick_id;
   logic                pick_vld;
   logic                cur_req;
   logic [num_req-1:0]  gnt_onehot;

   for (genvar i = 0; i < num_req; i++) begin : g_slice
      assign slice[i] = req_data[i*width +: width];
   end

   rr_pick #(
      .num_req (num_req),
      .idw     (idw)
   ) u_rr_pick (
      .req  (req),
      .last (gnt_id),
      .next (pick_id),
      .vld  (pick_vld)
   );

   assign busy       = (state == BURST);
   assign cur_req    = req[gnt_id];
   assign gnt_onehot = num_req'(1) << gnt_id;
   assign winc       = busy & cur_req & ~full;
   assign ack        = {num_req{winc}} & gnt_onehot;
   assign w_data     = busy ? slice[gnt_id] : '0;

   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         state  <= IDLE;
         gnt_id <= idw'(num_req - 1);
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt_id <= pick_id;
                  cnt    <= '0;
                  state  <= BURST;
               end
            end
            BURST: begin
               // A dropped request releases the grant even while full is stalling.
               if (!cur_req) begin
                  state <= IDLE;
               end else if (winc) begin
                  cnt <= cnt + cw'(1);
                  if (cnt + cw'(1) == burst_c) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WR_ARB_STATS_EN
   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         stall_cnt <= '0;
      end else if (stats_clr) begin
         stall_cnt <= '0;
      end else if (busy && cur_req && full && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter: table-driven cycle vectors, a write-order scoreboard
// fed by a behavioural depth-8 FIFO model, and hand sequences for reset and idle.
module tb_async_fifo_wr_arbiter;

   localparam int width   = 8;
   localparam int num_req = 4;
   localparam int burst   = 4;
   localparam int depth   = 8;
   localparam logic [31:0] fixed_data = 32'hA3A2A1A0;

   logic                     w_clk = 1'b0;
   logic                     w_rst;
   logic [num_req-1:0]       req;
   logic [num_req*width-1:0] req_data;
   logic [num_req-1:0]       ack;
   logic                     full;
   logic                     winc;
   logic [width-1:0]         w_data;
   logic [1:0]               gnt_id;
   logic                     busy;
`ifdef WR_ARB_STATS_EN
   logic                     stats_clr;
   logic [15:0]              stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      int         id;
      int         cyc;
   } exp_t;

   typedef struct packed {
      logic [3:0] req;
      logic       full;
      logic       winc;
      logic [3:0] ack;
      logic       busy;
      logic [1:0] gnt;
      logic [7:0] wd;
   } vec_t;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int         n[num_req];
   int         tot[num_req];
   int         cyc;
   int         rd_on;
   int         probe_cyc;
   vec_t       tbl[20];

   always #5 w_clk = ~w_clk;

   async_fifo_wr_arbiter #(
      .width   (width),
      .num_req (num_req),
      .burst   (burst)
   ) dut (
      .w_clk    (w_clk),
      .w_rst    (w_rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .full     (full),
      .winc     (winc),
      .w_data   (w_data),
      .gnt_id   (gnt_id),
      .busy     (busy)
`ifdef WR_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic start_scn(input int t0, input int t1, input int t2, input int t3);
      tot[0] = t0; tot[1] = t1; tot[2] = t2; tot[3] = t3;
      for (int i = 0; i < num_req; i++) n[i] = 0;
      exp_q.delete();
      fifo_q.delete();
      cyc = 0;
   endtask

   task automatic drive_model();
      for (int i = 0; i < num_req; i++) begin
         req[i] = (n[i] < tot[i]);
         req_data[i*width +: width] = 8'(i*16 + n[i]);
      end
      full = (fifo_q.size() >= depth);
   endtask

   task automatic monitor_model();
      exp_t e;
      if (full) chk("hold_on_full", 32'({winc, ack}), 32'(0));
      if (cyc == probe_cyc)
         chk("stall_grant_held", 32'({busy, winc, ack, gnt_id}), 32'({1'b1, 1'b0, 4'b0000, 2'd1}));
      if (!winc) chk("ack_without_winc", 32'(ack), 32'(0));
      if (rd_en_now() && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (winc) begin
         if (exp_q.size() == 0) begin
            chk("extra_write", 32'(w_data), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("w_data", 32'(w_data), 32'(e.data));
            chk("ack", 32'(ack), 32'(4'b0001 << e.id));
            if (e.cyc >= 0) chk("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
         for (int i = 0; i < num_req; i++) if (ack[i]) n[i]++;
         fifo_q.push_back(w_data);
      end
   endtask

   function automatic bit rd_en_now();
      return (cyc >= rd_on);
   endfunction

   task automatic step_model();
      @(negedge w_clk);
      drive_model();
      #1;
      monitor_model();
      cyc++;
   endtask

   task automatic run_model(input int budget);
      while (exp_q.size() > 0 && cyc < budget) step_model();
      if (exp_q.size() > 0) begin
         chk("timeout_words_left", 32'(exp_q.size()), 32'(0));
         exp_q.delete();
      end
      repeat (3) step_model();
   endtask

   function automatic int burst_cyc(input int base, input int j);
      return base + (j / burst) * (burst + 1) + (j % burst);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      w_rst     = 1'b0;
      req       = '0;
      req_data  = '0;
      full      = 1'b0;
      rd_on     = 0;
      probe_cyc = -1;
`ifdef WR_ARB_STATS_EN
      stats_clr = 1'b0;
`endif

      // Vectors: {req, full} -> {winc, ack, busy, gnt_id, w_data}, from reset state.
      tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00};
      tbl[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00};
      tbl[2]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
      tbl[3]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
      tbl[4]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
      tbl[5]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
      tbl[6]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
      tbl[7]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
      tbl[8]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
      tbl[9]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h00};
      tbl[10] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
      tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
      tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h00};
      tbl[13] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
      tbl[14] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
      tbl[15] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
      tbl[16] = '{4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
      tbl[17] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2};
      tbl[18] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2};
      tbl[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h00};

      repeat (2) @(negedge w_clk);
      #1;
      chk("reset_out", 32'({winc, ack, busy, gnt_id, w_data}),
          32'({1'b0, 4'b0000, 1'b0, 2'd3, 8'h00}));
`ifdef WR_ARB_STATS_EN
      chk("reset_stall_cnt", 32'(stall_cnt), 32'(0));
`endif
      w_rst = 1'b1;

      // All four requesters, two rounds: grants 0,1,2,3,0,1,2,3 with one bubble each.
      start_scn(8, 8, 8, 8);
      rd_on = 0;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < num_req; i++)
            for (int k = 0; k < burst; k++)
               exp_q.push_back('{8'(i*16 + r*4 + k), i, burst_cyc(1, r*16 + i*4 + k)});
      run_model(80);

      // Single requester 2 streaming 10 words: bursts of 4,4,2.
      start_scn(0, 0, 10, 0);
      for (int j = 0; j < 10; j++) exp_q.push_back('{8'(32 + j), 2, burst_cyc(1, j)});
      run_model(60);

`ifdef WR_ARB_STATS_EN
      @(negedge w_clk); stats_clr = 1'b1;
      @(negedge w_clk); stats_clr = 1'b0;
`endif

      // FIFO fills with reads off; requester 1 stalls on full until reads resume at cycle 20.
      start_scn(0, 20, 0, 0);
      rd_on     = 20;
      probe_cyc = 15;
      for (int j = 0; j < 20; j++)
         exp_q.push_back('{8'(16 + j), 1, (j < 8) ? burst_cyc(1, j) : burst_cyc(21, j - 8)});
      run_model(120);
      probe_cyc = -1;
      rd_on     = 0;
`ifdef WR_ARB_STATS_EN
      chk("stall_cnt_fifo", 32'(stall_cnt), 32'(10));
`endif

      // Cycle vectors from a fresh reset.
      @(negedge w_clk); w_rst = 1'b0;
      @(negedge w_clk); w_rst = 1'b1;
      for (int r = 0; r < 20; r++) begin
         @(negedge w_clk);
         req      = tbl[r].req;
         full     = tbl[r].full;
         req_data = fixed_data;
         #1;
         chk($sformatf("vec%0d", r), 32'({winc, ack, busy, gnt_id, w_data}),
             32'({tbl[r].winc, tbl[r].ack, tbl[r].busy, tbl[r].gnt, tbl[r].wd}));
      end
`ifdef WR_ARB_STATS_EN
      chk("stall_cnt_vec", 32'(stall_cnt), 32'(4));
`endif

      // Reset asserted mid-burst: outputs drop immediately, then requester 0 wins first.
      @(negedge w_clk);
      req = 4'b1111; full = 1'b0; req_data = fixed_data;
      @(negedge w_clk); #1;
      chk("rst_pre_burst", 32'({busy, winc, gnt_id}), 32'({1'b1, 1'b1, 2'd3}));
      @(negedge w_clk); #1;
      w_rst = 1'b0;
      #1;
      chk("rst_async_drop", 32'({winc, ack, busy, gnt_id, w_data}),
          32'({1'b0, 4'b0000, 1'b0, 2'd3, 8'h00}));
      @(negedge w_clk); w_rst = 1'b1;
      @(negedge w_clk); #1;
      chk("rst_first_gnt", 32'({busy, winc, ack, gnt_id, w_data}),
          32'({1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0}));

      // No requests for 20 cycles.
      for (int c = 0; c < 20; c++) begin
         @(negedge w_clk);
         req = '0;
         #1;
         if (c >= 1) chk($sformatf("idle%0d", c), 32'({winc, busy, ack, w_data}), 32'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
